// File: rtl/cpu_prog_loader_if.sv
// Byte-stream bundle for cpu_prog_loader.
//   s_data/s_valid/s_ready : inbound program frame (loader is the sink)
//   m_data/m_valid/m_ready : outbound register/memory dump (loader is the source)
// Modports:
//   slave  - loader side
//   master - frame producer / dump consumer side
interface cpu_prog_loader_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;

    modport slave (
        input  s_data,
        input  s_valid,
        input  m_ready,
        output s_ready,
        output m_data,
        output m_valid
    );

    modport master (
        output s_data,
        output s_valid,
        output m_ready,
        input  s_ready,
        input  m_data,
        input  m_valid
    );
endinterface

// File: rtl/cpu_prog_loader.sv
// Byte-stream front end for the 8-bit CPU.
// Accepts a frame {LEN, DCNT, LEN program bytes}, resets the CPU, writes the program one
// byte per clock, waits for done (or a timeout), then streams r0..r7, DM[0..DCNT-1] and a
// trailer status byte (0x00 done, 0xEE timeout).
// Ports:
//   clk, rst       clock; synchronous active-low reset
//   bus            stream bundle (slave side): inbound frame, outbound dump
//   o_cpu_rst      CPU reset, active-high
//   o_isReg        readback select: 1 = register file, 0 = data memory
//   o_cpu_addr     load / readback address
//   o_inst         instruction byte to CPU
//   i_CPU_data     readback data, valid one cycle after address/select change
//   i_is_done      CPU program finished
//   o_busy         high outside IDLE
module cpu_prog_loader #(
    parameter int unsigned RUN_TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    cpu_prog_loader_if.slave bus,
    output logic             o_cpu_rst,
    output logic             o_isReg,
    output logic [7:0]       o_cpu_addr,
    output logic [7:0]       o_inst,
    input  logic [7:0]       i_CPU_data,
    input  logic             i_is_done,
    output logic             o_busy
);

    localparam logic [15:0] TimeoutLast = 16'(RUN_TIMEOUT - 1);
    localparam logic [7:0]  StatusOk    = 8'h00;
    localparam logic [7:0]  StatusTmo   = 8'hEE;

    typedef enum logic [2:0] {
        StIdle, StHdr, StCrst, StLoad, StRun, StRdReg, StRdDm, StTrail
    } state_e;

    // Readback item: address presented, data captured, waiting on sink.
    typedef enum logic [1:0] {PhAddr, PhCap, PhOut} phase_e;

    state_e      state_q, state_d;
    phase_e      phase_q, phase_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  dcnt_q, dcnt_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  inst_q, inst_d;
    logic [15:0] run_cnt_q, run_cnt_d;
    logic [7:0]  status_q, status_d;
    logic [7:0]  m_data_q, m_data_d;
    logic        m_valid_q, m_valid_d;

    logic s_ready;
    logic s_acc;
    logic m_hs;
    logic rd_last;

    assign s_ready = rst && (state_q inside {StIdle, StHdr, StLoad});
    assign s_acc   = bus.s_valid && s_ready;
    assign m_hs    = m_valid_q && bus.m_ready;
    assign rd_last = (state_q == StRdReg) ? (addr_q == 8'd7) : (addr_q == dcnt_q - 8'd1);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        len_d     = len_q;
        dcnt_d    = dcnt_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        inst_d    = inst_q;
        run_cnt_d = run_cnt_q;
        status_d  = status_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;

        unique case (state_q)
            StIdle: begin
                if (s_acc) begin
                    len_d   = bus.s_data;
                    state_d = StHdr;
                end
            end
            StHdr: begin
                if (s_acc) begin
                    dcnt_d  = bus.s_data;
                    state_d = StCrst;
                end
            end
            StCrst: begin
                cnt_d     = 8'd0;
                run_cnt_d = 16'd0;
                state_d   = (len_q == 8'd0) ? StRun : StLoad;
            end
            StLoad: begin
                if (s_acc) begin
                    addr_d = cnt_q;
                    inst_d = bus.s_data;
                    cnt_d  = cnt_q + 8'd1;
                    if (cnt_q == len_q - 8'd1) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                // Done is checked first so it wins over a same-cycle timeout.
                if (i_is_done || run_cnt_q == TimeoutLast) begin
                    status_d = i_is_done ? StatusOk : StatusTmo;
                    state_d  = StRdReg;
                    addr_d   = 8'd0;
                    phase_d  = PhAddr;
                end else begin
                    run_cnt_d = run_cnt_q + 16'd1;
                end
            end
            StRdReg, StRdDm: begin
                unique case (phase_q)
                    PhAddr: phase_d = PhCap;
                    PhCap: begin
                        m_data_d  = i_CPU_data;
                        m_valid_d = 1'b1;
                        phase_d   = PhOut;
                    end
                    PhOut: begin
                        if (m_hs) begin
                            m_valid_d = 1'b0;
                            phase_d   = PhAddr;
                            if (!rd_last) begin
                                addr_d = addr_q + 8'd1;
                            end else if (state_q == StRdReg && dcnt_q != 8'd0) begin
                                state_d = StRdDm;
                                addr_d  = 8'd0;
                            end else begin
                                // Trailer goes out on the very next cycle.
                                state_d   = StTrail;
                                m_data_d  = status_q;
                                m_valid_d = 1'b1;
                            end
                        end
                    end
                    default: phase_d = PhAddr;
                endcase
            end
            StTrail: begin
                if (m_hs) begin
                    m_valid_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            phase_q   <= PhAddr;
            len_q     <= 8'd0;
            dcnt_q    <= 8'd0;
            cnt_q     <= 8'd0;
            addr_q    <= 8'd0;
            inst_q    <= 8'd0;
            run_cnt_q <= 16'd0;
            status_q  <= 8'd0;
            m_data_q  <= 8'd0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            len_q     <= len_d;
            dcnt_q    <= dcnt_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            inst_q    <= inst_d;
            run_cnt_q <= run_cnt_d;
            status_q  <= status_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign bus.s_ready  = s_ready;
    assign bus.m_data   = m_data_q;
    assign bus.m_valid  = m_valid_q;
    assign o_cpu_rst    = !rst || (state_q inside {StIdle, StHdr, StCrst});
    assign o_isReg      = (state_q == StRdReg);
    assign o_cpu_addr   = addr_q;
    assign o_inst       = inst_q;
    assign o_busy       = (state_q != StIdle);

endmodule

// File: tb/tb_cpu_prog_loader.sv
// Self-checking bench for cpu_prog_loader: random frames, a CPU model with a registered
// readback port, a randomly stalling sink, and a scoreboard monitor on the dump stream.
module tb_cpu_prog_loader;
    localparam int Timeout = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       o_cpu_rst, o_isReg, o_busy, i_is_done;
    logic [7:0] o_cpu_addr, o_inst;
    logic [7:0] i_CPU_data = 8'd0;

    cpu_prog_loader_if bus ();

    cpu_prog_loader #(.RUN_TIMEOUT(Timeout)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .o_cpu_rst  (o_cpu_rst),
        .o_isReg    (o_isReg),
        .o_cpu_addr (o_cpu_addr),
        .o_inst     (o_inst),
        .i_CPU_data (i_CPU_data),
        .i_is_done  (i_is_done),
        .o_busy     (o_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // CPU model state
    logic [7:0] regs [8];
    logic [7:0] dm   [256];
    logic [7:0] prog [256];
    int done_at = -1;   // cycle (counted from CPU reset release) at which done rises
    int cyc     = 0;

    // Scoreboard
    logic [7:0] exp_q [$];
    int         lat_q [$];
    int         cnt_q [$];

    logic stall_r3  = 1'b0;
    logic sink_rand = 1'b0;
    int   stall_reqs = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // CPU: held in reset by o_cpu_rst, registered readback.
    always @(posedge clk) begin
        if (o_cpu_rst) cyc <= 0;
        else           cyc <= cyc + 1;
        i_CPU_data <= o_isReg ? regs[o_cpu_addr[2:0]] : dm[o_cpu_addr];
    end
    assign i_is_done = !o_cpu_rst && done_at >= 0 && cyc >= done_at;

    // Sink: random or always-ready, plus a directed stall burst on request.
    initial bus.m_ready = 1'b0;
    always @(posedge clk) begin
        int stall_left;
        int stall_seen;
        #1;
        if (stall_reqs != stall_seen) begin
            stall_seen = stall_reqs;
            stall_left = 7;
        end
        if (stall_left > 0) begin
            bus.m_ready = 1'b0;
            stall_left--;
        end else begin
            bus.m_ready = sink_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: compare every valid cycle against the queue head, pop on handshake.
    always @(negedge clk) begin
        int beats_left;
        int beat_idx;
        if (rst && bus.m_valid) begin
            if (beats_left == 0) begin
                if (cnt_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got 0x%0h, expected no output", bus.m_data);
                end else begin
                    beats_left = cnt_q.pop_front();
                    beat_idx   = 0;
                    check("first_beat_latency", cyc, lat_q.pop_front());
                end
            end
            if (beats_left > 0) begin
                check("dump_byte", bus.m_data, exp_q[0]);
                if (bus.m_ready) begin
                    void'(exp_q.pop_front());
                    beats_left--;
                    if (stall_r3 && beat_idx == 2) stall_reqs++;
                    beat_idx++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        @(negedge clk);
        while (!bus.s_ready) begin
            guard++;
            if (guard > 2000) begin
                $display("FAIL send_timeout: got s_ready=0, expected s_ready=1 within 2000 cycles");
                $fatal(1);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic randomize_cpu();
        for (int i = 0; i < 8; i++)   regs[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) dm[i]   = 8'($urandom);
        for (int i = 0; i < 256; i++) prog[i] = 8'($urandom);
    endtask

    // d: RUN cycle at which done rises (<0: never).
    task automatic run_frame(input int len, input int dcnt, input int d, input bit gaps);
        int r_exit;
        int guard;
        logic [7:0] status;
        bit done_in_time;
        done_in_time = (d >= 0) && (d < Timeout);
        r_exit = done_in_time ? d : Timeout - 1;
        status = done_in_time ? 8'h00 : 8'hEE;
        done_at = (d < 0) ? -1 : len + d;

        if (gaps) repeat ($urandom_range(0, 3)) tick();
        send_byte(8'(len));
        if (gaps) repeat ($urandom_range(0, 3)) tick();
        send_byte(8'(dcnt));
        check("crst_cpu_rst", o_cpu_rst, 1'b1);
        check("crst_s_ready", bus.s_ready, 1'b0);
        check("crst_busy", o_busy, 1'b1);

        if (len > 0) begin
            for (int k = 0; k < len; k++) begin
                send_byte(prog[k]);
                check("load_addr", o_cpu_addr, k);
                check("load_inst", o_inst, prog[k]);
                check("load_cpu_rst", o_cpu_rst, 1'b0);
            end
        end
        for (int i = 0; i < 8; i++)    exp_q.push_back(regs[i]);
        for (int i = 0; i < dcnt; i++) exp_q.push_back(dm[i]);
        exp_q.push_back(status);
        cnt_q.push_back(9 + dcnt);
        lat_q.push_back(len + r_exit + 3);
        if (len == 0) begin
            tick();
            check("run_cpu_rst", o_cpu_rst, 1'b0);
        end

        guard = 0;
        while ((exp_q.size() != 0 || o_busy) && guard < 3000) begin
            tick();
            guard++;
        end
        check("frame_drained", exp_q.size(), 0);
        check("frame_idle_busy", o_busy, 1'b0);
        check("idle_cpu_rst", o_cpu_rst, 1'b1);
        check("idle_m_valid", bus.m_valid, 1'b0);
    endtask

    initial begin
        rst         = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'd0;
        randomize_cpu();
        repeat (3) tick();

        check("rst_s_ready", bus.s_ready, 1'b0);
        check("rst_m_valid", bus.m_valid, 1'b0);
        check("rst_m_data", bus.m_data, 8'd0);
        check("rst_isreg", o_isReg, 1'b0);
        check("rst_addr", o_cpu_addr, 8'd0);
        check("rst_inst", o_inst, 8'd0);
        check("rst_cpu_rst", o_cpu_rst, 1'b1);
        check("rst_busy", o_busy, 1'b0);
        rst = 1'b1;
        tick();
        check("idle_s_ready", bus.s_ready, 1'b1);

        // Abort a frame after 3 of 10 program bytes.
        done_at = -1;
        send_byte(8'd10);
        send_byte(8'd5);
        for (int k = 0; k < 3; k++) send_byte(8'hF0 + 8'(k));
        check("abort_pre_addr", o_cpu_addr, 8'd2);
        check("abort_pre_cpu_rst", o_cpu_rst, 1'b0);
        rst = 1'b0;
        tick();
        check("abort_busy", o_busy, 1'b0);
        check("abort_cpu_rst", o_cpu_rst, 1'b1);
        check("abort_m_valid", bus.m_valid, 1'b0);
        check("abort_addr", o_cpu_addr, 8'd0);
        check("abort_inst", o_inst, 8'd0);
        rst = 1'b1;
        tick();

        // Directed frame: r0..r7 = 10..17, DM = AA BB, stall on r3.
        for (int i = 0; i < 8; i++) regs[i] = 8'(10 + i);
        dm[0] = 8'hAA;
        dm[1] = 8'hBB;
        prog[0] = 8'h12; prog[1] = 8'h34; prog[2] = 8'h56; prog[3] = 8'h78;
        sink_rand = 1'b0;
        stall_r3  = 1'b1;
        run_frame(4, 2, 20, 1'b0);
        stall_r3  = 1'b0;

        // Timeout, empty frame, done/timeout coincidence, just past the limit.
        randomize_cpu();
        run_frame(3, 1, -1, 1'b0);
        randomize_cpu();
        run_frame(0, 0, 5, 1'b0);
        randomize_cpu();
        run_frame(2, 3, Timeout - 1, 1'b0);
        randomize_cpu();
        run_frame(1, 0, Timeout, 1'b0);

        // Random frames with a stalling sink.
        sink_rand = 1'b1;
        randomize_cpu();
        run_frame(255, 255, 0, 1'b1);
        for (int t = 0; t < 10; t++) begin
            int len, dcnt, d;
            randomize_cpu();
            len  = $urandom_range(0, 20);
            dcnt = $urandom_range(0, 10);
            d    = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, Timeout + 4));
            run_frame(len, dcnt, d, 1'b1);
        end

        repeat (5) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
